// File: rtl/bp_io_cmd_arbiter.sv
// bp_io_cmd_arbiter: round-robin IO command arbiter with credit limit and in-order response steering
module bp_io_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4,
  localparam int lg_req_lp = $clog2(num_req_p),
  localparam int cnt_w_lp  = $clog2(max_outstanding_p+1),
  localparam int ptr_w_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] req_msg_i,
  input  logic [num_req_p-1:0]             req_v_i,
  output logic [num_req_p-1:0]             req_yumi_o,
  output logic [msg_width_p-1:0]           cmd_o,
  output logic                             cmd_v_o,
  input  logic                             cmd_ready_and_i,
  input  logic [msg_width_p-1:0]           resp_i,
  input  logic                             resp_v_i,
  output logic                             resp_yumi_o,
  output logic [msg_width_p-1:0]           resp_o,
  output logic [num_req_p-1:0]             resp_v_o,
  input  logic [num_req_p-1:0]             resp_ready_and_i,
  output logic [cnt_w_lp-1:0]              outstanding_o,
  output logic                             idle_o,
  output logic                             error_o
);
  logic [msg_width_p-1:0] cmd_r;
  logic                   cmd_v_r;
  logic [lg_req_lp-1:0]   last_r;
  logic [cnt_w_lp-1:0]    cnt_r;
  logic [ptr_w_lp-1:0]    rd_ptr_r, wr_ptr_r;
  logic [lg_req_lp-1:0]   tags_r [max_outstanding_p];
  logic                   error_r;
  logic                   buf_free, grant_en, grant_v, push, pop, nonempty;
  logic [lg_req_lp-1:0]   grant_idx, head;
  logic [msg_width_p-1:0] grant_msg;

  assign buf_free  = ~cmd_v_r | (cmd_v_r & cmd_ready_and_i);
  assign grant_en  = buf_free & (cnt_r < cnt_w_lp'(max_outstanding_p));
  assign push      = grant_en & grant_v & ~reset_i;
  assign grant_msg = req_msg_i[grant_idx*msg_width_p +: msg_width_p];
  assign nonempty  = cnt_r != '0;
  assign head      = tags_r[rd_ptr_r];
  assign pop       = resp_v_i & nonempty & resp_ready_and_i[head];

  assign cmd_o         = cmd_r;
  assign cmd_v_o       = cmd_v_r;
  assign resp_o        = resp_i;
  assign resp_yumi_o   = pop;
  assign outstanding_o = cnt_r;
  assign idle_o        = (cnt_r == '0) & ~cmd_v_r;
  assign error_o       = error_r;

  // Round-robin scan starting just after the last winner
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= num_req_p; k++) begin
      int j;
      j = (int'(last_r) + k) % num_req_p;
      if (!grant_v && req_v_i[j]) begin
        grant_v   = 1'b1;
        grant_idx = lg_req_lp'(j);
      end
    end
  end

  // One-hot grant and one-hot response steering to the FIFO head owner
  always_comb begin
    req_yumi_o            = '0;
    req_yumi_o[grant_idx] = push;
    resp_v_o              = '0;
    resp_v_o[head]        = resp_v_i & nonempty;
  end

  // Tag storage; contents are meaningless while the pointers say empty
  always_ff @(posedge clk_i) begin
    if (push) tags_r[wr_ptr_r] <= grant_idx;
  end

  // Output buffer, round-robin pointer, credits, FIFO pointers and sticky error
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_r    <= '0;
      cmd_v_r  <= 1'b0;
      last_r   <= lg_req_lp'(num_req_p-1);
      cnt_r    <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      error_r  <= 1'b0;
    end else begin
      if (push) begin
        cmd_r    <= grant_msg;
        cmd_v_r  <= 1'b1;
        last_r   <= grant_idx;
        wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(max_outstanding_p-1)) ? '0 : wr_ptr_r + 1'b1;
      end else if (cmd_v_r & cmd_ready_and_i) begin
        cmd_v_r <= 1'b0;
      end
      if (pop) rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(max_outstanding_p-1)) ? '0 : rd_ptr_r + 1'b1;
      cnt_r <= cnt_r + cnt_w_lp'(push) - cnt_w_lp'(pop);
      if (resp_v_i & ~nonempty) error_r <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// tb_bp_io_cmd_arbiter: directed self-checking bench for bp_io_cmd_arbiter
module tb_bp_io_cmd_arbiter;
  localparam int w = 16;
  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [2*w-1:0] req_msg_i;
  logic [1:0]    req_v_i, req_yumi_o, resp_v_o, resp_ready_and_i;
  logic [w-1:0]  cmd_o, resp_i, resp_o;
  logic          cmd_v_o, cmd_ready_and_i, resp_v_i, resp_yumi_o, idle_o, error_o;
  logic [2:0]    outstanding_o;
  int            n_cmp = 0, n_err = 0, grants;

  bp_io_cmd_arbiter #(.num_req_p(2), .msg_width_p(w), .max_outstanding_p(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_msg_i(req_msg_i), .req_v_i(req_v_i),
    .req_yumi_o(req_yumi_o), .cmd_o(cmd_o), .cmd_v_o(cmd_v_o), .cmd_ready_and_i(cmd_ready_and_i),
    .resp_i(resp_i), .resp_v_i(resp_v_i), .resp_yumi_o(resp_yumi_o), .resp_o(resp_o),
    .resp_v_o(resp_v_o), .resp_ready_and_i(resp_ready_and_i), .outstanding_o(outstanding_o),
    .idle_o(idle_o), .error_o(error_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic cr, input logic sv, input logic [1:0] sr);
    req_v_i = rv; cmd_ready_and_i = cr; resp_v_i = sv; resp_ready_and_i = sr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    req_msg_i = {16'hB001, 16'hA000};
    resp_i = 16'h5A5A;
    drive(2'b00, 1'b1, 1'b0, 2'b11);
    #12;
    chk("rst_cmd_v", 32'(cmd_v_o), 0);
    chk("rst_cmd", 32'(cmd_o), 0);
    chk("rst_yumi", 32'(req_yumi_o), 0);
    chk("rst_out", 32'(outstanding_o), 0);
    chk("rst_idle", 32'(idle_o), 1);
    chk("rst_err", 32'(error_o), 0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    // round robin with responses returned each cycle
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, i > 0, 2'b11);
      chk("rr_yumi", 32'(req_yumi_o), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i > 0) chk("rr_resp_v", 32'(resp_v_o), ((i-1) % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_resp_data", 32'(resp_o), 32'h5A5A);
      tick;
      chk("rr_cmd", 32'(cmd_o), (i % 2 == 0) ? 32'hA000 : 32'hB001);
      chk("rr_cmd_v", 32'(cmd_v_o), 1);
    end
    chk("rr_out", 32'(outstanding_o), 1);
    drive(2'b00, 1'b1, 1'b1, 2'b11);
    chk("rr_last_resp", 32'(resp_v_o), 2);
    tick;
    chk("rr_idle", 32'(idle_o), 1);
    // credit limit: requester 0 streams, no responses
    for (int i = 0; i < 4; i++) begin
      req_msg_i[15:0] = 16'h1000 + 16'(i);
      drive(2'b01, 1'b1, 1'b0, 2'b11);
      chk("cr_yumi", 32'(req_yumi_o), 1);
      tick;
      chk("cr_out", 32'(outstanding_o), i + 1);
      chk("cr_cmd", 32'(cmd_o), 32'h1000 + i);
    end
    drive(2'b01, 1'b1, 1'b0, 2'b11);
    chk("cr_block", 32'(req_yumi_o), 0);
    tick;
    chk("cr_full", 32'(outstanding_o), 4);
    chk("cr_cmd_drained", 32'(cmd_v_o), 0);
    drive(2'b01, 1'b1, 1'b1, 2'b11);
    chk("cr_no_bypass", 32'(req_yumi_o), 0);
    chk("cr_resp_yumi", 32'(resp_yumi_o), 1);
    tick;
    chk("cr_out3", 32'(outstanding_o), 3);
    drive(2'b01, 1'b1, 1'b0, 2'b11);
    chk("cr_regrant", 32'(req_yumi_o), 1);
    tick;
    chk("cr_out4", 32'(outstanding_o), 4);
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 1'b1, 1'b1, 2'b11);
      chk("cr_drain_v", 32'(resp_v_o), 1);
      tick;
    end
    chk("cr_empty", 32'(outstanding_o), 0);
    // steering: issue 1,0,1
    drive(2'b10, 1'b1, 1'b0, 2'b11); chk("st_g1", 32'(req_yumi_o), 2); tick;
    drive(2'b01, 1'b1, 1'b0, 2'b11); chk("st_g0", 32'(req_yumi_o), 1); tick;
    drive(2'b10, 1'b1, 1'b0, 2'b11); chk("st_g1b", 32'(req_yumi_o), 2); tick;
    chk("st_out", 32'(outstanding_o), 3);
    drive(2'b00, 1'b1, 1'b1, 2'b01);
    chk("st_stall_v", 32'(resp_v_o), 2);
    chk("st_stall_yumi", 32'(resp_yumi_o), 0);
    tick;
    chk("st_stall_out", 32'(outstanding_o), 3);
    drive(2'b00, 1'b1, 1'b1, 2'b11); chk("st_r0", 32'(resp_v_o), 2); chk("st_y0", 32'(resp_yumi_o), 1); tick;
    drive(2'b00, 1'b1, 1'b1, 2'b11); chk("st_r1", 32'(resp_v_o), 1); tick;
    drive(2'b00, 1'b1, 1'b1, 2'b11); chk("st_r2", 32'(resp_v_o), 2); tick;
    chk("st_empty", 32'(outstanding_o), 0);
    // backpressure: five stalled cycles, both requesters valid
    req_msg_i = {16'hD1D1, 16'hC0C0};
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 1'b0, 1'b0, 2'b11);
      if (req_yumi_o != 2'b00) grants++;
      tick;
      chk("bp_cmd", 32'(cmd_o), 32'hC0C0);
    end
    chk("bp_grants", 32'(grants), 1);
    drive(2'b11, 1'b1, 1'b0, 2'b11);
    chk("bp_release_yumi", 32'(req_yumi_o), 2);
    tick;
    chk("bp_reload", 32'(cmd_o), 32'hD1D1);
    chk("bp_out", 32'(outstanding_o), 2);
    drive(2'b01, 1'b1, 1'b0, 2'b11); tick;
    chk("sim_out3", 32'(outstanding_o), 3);
    // simultaneous grant and response at three outstanding
    drive(2'b10, 1'b1, 1'b1, 2'b11);
    chk("sim_yumi", 32'(req_yumi_o), 2);
    chk("sim_resp_v", 32'(resp_v_o), 1);
    chk("sim_resp_yumi", 32'(resp_yumi_o), 1);
    tick;
    chk("sim_out", 32'(outstanding_o), 3);
    drive(2'b00, 1'b1, 1'b1, 2'b11); chk("sim_o0", 32'(resp_v_o), 2); tick;
    drive(2'b00, 1'b1, 1'b1, 2'b11); chk("sim_o1", 32'(resp_v_o), 1); tick;
    drive(2'b00, 1'b1, 1'b1, 2'b11); chk("sim_o2", 32'(resp_v_o), 2); tick;
    chk("sim_empty", 32'(outstanding_o), 0);
    // response with an empty FIFO
    drive(2'b00, 1'b1, 1'b1, 2'b11);
    chk("err_yumi", 32'(resp_yumi_o), 0);
    chk("err_v", 32'(resp_v_o), 0);
    tick;
    chk("err_set", 32'(error_o), 1);
    drive(2'b00, 1'b1, 1'b0, 2'b11); tick;
    chk("err_sticky", 32'(error_o), 1);
    // reset mid-stream with two outstanding
    drive(2'b11, 1'b1, 1'b0, 2'b11); tick;
    drive(2'b11, 1'b1, 1'b0, 2'b11); tick;
    chk("mr_out2", 32'(outstanding_o), 2);
    reset_i = 1'b1;
    #1;
    chk("mr_cmd_v", 32'(cmd_v_o), 0);
    chk("mr_cmd", 32'(cmd_o), 0);
    chk("mr_yumi", 32'(req_yumi_o), 0);
    chk("mr_out", 32'(outstanding_o), 0);
    chk("mr_idle", 32'(idle_o), 1);
    chk("mr_err", 32'(error_o), 0);
    tick;
    reset_i = 1'b0;
    drive(2'b11, 1'b0, 1'b0, 2'b11);
    chk("mr_prio0", 32'(req_yumi_o), 1);
    drive(2'b00, 1'b1, 1'b1, 2'b11); tick;
    chk("mr_late_resp_err", 32'(error_o), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bp_io_cmd_arbiter.md
# bp_io_cmd_arbiter

Shares one outbound IO command channel between `num_req_p` requesters (e.g. the IO CCE and a debug/config master) in front of the IO-NoC memory link. It grants with round-robin priority, registers the winning command into a one-entry output buffer, and limits outstanding commands with a credit counter. Responses arrive in command order; a tag FIFO records the issuing requester so each response is steered back to it.

## Interface
- `num_req_p`, default 2: number of requesters; must be ≥ 2.
- `msg_width_p`, default 128: width of the opaque command/response message (header + data).
- `max_outstanding_p`, default 4: maximum issued-but-unanswered commands; also the tag FIFO depth.
- `clk_i`, in, 1: clock.
- `reset_i`, in, 1: reset, asynchronous, active-high.
- `req_msg_i`, in, `num_req_p*msg_width_p`: per-requester command; requester i occupies slice i.
- `req_v_i`, in, `num_req_p`: per-requester command valid.
- `req_yumi_o`, out, `num_req_p`: one-hot grant/consume; at most one bit high.
- `cmd_o`, out, `msg_width_p`: registered winning command.
- `cmd_v_o`, out, 1: output buffer holds a command.
- `cmd_ready_and_i`, in, 1: downstream accepts when `cmd_v_o & cmd_ready_and_i`.
- `resp_i`, in, `msg_width_p`: response from downstream.
- `resp_v_i`, in, 1: response valid.
- `resp_yumi_o`, out, 1: response consumed.
- `resp_o`, out, `msg_width_p`: response broadcast to all requesters (equals `resp_i`).
- `resp_v_o`, out, `num_req_p`: one-hot valid to the owning requester.
- `resp_ready_and_i`, in, `num_req_p`: per-requester response ready.
- `outstanding_o`, out, `$clog2(max_outstanding_p+1)`: current credit count in use.
- `idle_o`, out, 1: `outstanding_o==0 & ~cmd_v_o`; used for fences.
- `error_o`, out, 1: sticky; set when a response arrives with the tag FIFO empty.

## Operation
- State:
  - output buffer (`cmd_r`, `cmd_v_r`)
  - round-robin pointer `last_r` (index of the last granted requester)
  - credit counter `cnt_r`
  - tag FIFO of `$clog2(num_req_p)`-bit requester indices, depth `max_outstanding_p`
  - `error_r`
- Buffer free: `~cmd_v_r | (cmd_v_o & cmd_ready_and_i)`.
- Grant enable: `buffer_free & (cnt_r < max_outstanding_p)`. There is no bypass from a same-cycle response.
- Arbitration: scan requesters from `last_r+1` upward, wrapping modulo `num_req_p`. The first with `req_v_i` set wins.
- On grant of requester i, all of the following happen in the same cycle:
  - `req_yumi_o[i]=1`
  - `cmd_r <= req_msg_i[i]`, `cmd_v_r <= 1`
  - `last_r <= i`
  - push i into the tag FIFO
  - `cnt_r` increments
- No grant while downstream drains the buffer: `cmd_v_r` clears.
- Response path, combinational:
  - `h` = FIFO head; `resp_v_o[h] = resp_v_i & fifo_nonempty`; all other bits are 0.
  - `resp_yumi_o = resp_v_i & fifo_nonempty & resp_ready_and_i[h]`.
  - On `resp_yumi_o`: pop the FIFO and decrement `cnt_r`.
- Grant and response in the same cycle: FIFO push and pop both occur; `cnt_r` is unchanged.
- `resp_v_i` with FIFO empty: the response is not consumed (`resp_yumi_o=0`) and `error_r` sets, then holds until reset.
- The credit counter never exceeds `max_outstanding_p` and never underflows. Pops occur only when the FIFO is non-empty, and `cnt_r` equals the FIFO occupancy at all times.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `cmd_v_o=0`, `cmd_o=0`, `req_yumi_o=0`
  - `cnt_r=0`, FIFO empty
  - `last_r=num_req_p-1`, so requester 0 has first priority
  - `error_o=0`, `idle_o=1`
- Reset mid-operation discards the buffered command and all tags. Responses to pre-reset commands that arrive afterwards set `error_o`.
- Command latency: grant in cycle N, `cmd_v_o=1` in cycle N+1. The buffer can drain and reload in the same cycle, giving one command per cycle sustained.
- `req_yumi_o` depends combinationally on `req_v_i`, `cmd_ready_and_i`, `cnt_r` and `last_r`. It does not depend on response-side signals.
- Response latency is 0 cycles (combinational pass-through). `resp_yumi_o` depends on `resp_v_i` and `resp_ready_and_i`.
- `cmd_o` is stable while `cmd_v_o & ~cmd_ready_and_i`.

## Test plan
- **Round robin.** Both requesters hold `req_v_i=2'b11` with `cmd_ready_and_i=1` and responses returned each cycle → grants alternate 0,1,0,1. `cmd_o` carries the matching payloads one cycle after each grant.
- **Credit limit.** `max_outstanding_p=4`, no responses, requester 0 streaming → exactly 4 grants, then `req_yumi_o=0` with `outstanding_o=4`. One response is consumed → the next grant occurs the following cycle and `outstanding_o` returns to 4.
- **Steering.** Issue the order 1,0,1 and return 3 responses → `resp_v_o` sequence is `2'b10, 2'b01, 2'b10`. Holding `resp_ready_and_i[1]=0` on the first response stalls it: `resp_yumi_o=0` and the FIFO is unchanged.
- **Backpressure.** `cmd_ready_and_i=0` for 5 cycles with both requesters valid → 1 grant total. `cmd_o` stays constant, then drains and reloads in the release cycle.
- **Simultaneous.** At `outstanding_o=3` with `max_outstanding_p=4`, a grant and a response consume happen in the same cycle → `outstanding_o` stays 3 and the FIFO order is preserved.
- **Error and reset.** `resp_v_i=1` with an empty FIFO → `error_o=1`, `resp_yumi_o=0`. Assert `reset_i` mid-stream with 2 outstanding → all outputs return to reset values immediately, with `idle_o=1`.
